// File: rtl/swc_pump_pkg.sv
// Defaults and FSM state encoding shared by the packet memory write and read pumps.
package swc_pump_pkg;

  localparam int DEF_PAGE_ADDR_BITS = 10;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MULTIPLY       = 16;

  localparam logic [0:0] ST_FILL      = 1'b0;
  localparam logic [0:0] ST_WAIT_SYNC = 1'b1;

  // Word counter width; never collapses to zero bits for a one-word line.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swc_packet_mem_write_pump.sv
// Packs MULTIPLY input words into one wide memory line and writes it out in the
// next rotating sync slot; word 0 occupies the most significant lane.
module swc_packet_mem_write_pump
  import swc_pump_pkg::*;
#(
  parameter int PAGE_ADDR_BITS = DEF_PAGE_ADDR_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MULTIPLY       = DEF_MULTIPLY
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [PAGE_ADDR_BITS-1:0]      pgaddr_i,
  input  logic                           pgreq_i,
  input  logic [DATA_WIDTH-1:0]          d_i,
  input  logic                           drdy_i,
  input  logic                           flush_i,
  output logic                           full_o,
  input  logic                           sync_i,
  output logic                           we_o,
  output logic [PAGE_ADDR_BITS-1:0]      addr_o,
  output logic [DATA_WIDTH*MULTIPLY-1:0] q_o,
  output logic                           pgend_o
);

  localparam int CNT_W  = cnt_width(MULTIPLY);
  localparam int LINE_W = DATA_WIDTH * MULTIPLY;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULTIPLY - 1);

  logic [0:0]                state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [LINE_W-1:0]         line_reg, line_next;
  logic [PAGE_ADDR_BITS-1:0] page_reg;
  logic [PAGE_ADDR_BITS-1:0] addr_reg, addr_next;
  logic                      full_reg;
  logic                      pgend_reg;
  logic                      accept;
  logic                      close_line;
  logic                      commit;

  assign accept = (state_reg == ST_FILL) && drdy_i;
  // A flush only closes the line if it holds at least one word, counting one arriving now.
  assign close_line = (state_reg == ST_FILL) &&
                      ((accept && (cnt_reg == CNT_LAST)) ||
                       (flush_i && (accept || (cnt_reg != '0))));
  assign commit = (state_reg == ST_WAIT_SYNC) && sync_i;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    line_next  = line_reg;
    addr_next  = addr_reg;
    if (commit) begin
      state_next = ST_FILL;
      cnt_next   = '0;
      line_next  = '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < MULTIPLY; k++) begin
          if (cnt_reg == CNT_W'(k)) begin
            line_next[DATA_WIDTH*(MULTIPLY-k)-1 -: DATA_WIDTH] = d_i;
          end
        end
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
      end
      if (close_line) begin
        state_next = ST_WAIT_SYNC;
        cnt_next   = '0;
        addr_next  = page_reg;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_FILL;
      cnt_reg   <= '0;
      line_reg  <= '0;
      page_reg  <= '0;
      addr_reg  <= '0;
      full_reg  <= 1'b0;
      pgend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      line_reg  <= line_next;
      addr_reg  <= addr_next;
      full_reg  <= (state_next == ST_WAIT_SYNC);
      pgend_reg <= commit;
      if (pgreq_i) begin
        page_reg <= pgaddr_i;
      end
    end
  end

  assign full_o  = full_reg;
  assign we_o    = commit;
  assign addr_o  = addr_reg;
  assign q_o     = line_reg;
  assign pgend_o = pgend_reg;

endmodule

// File: doc/swc_packet_mem_write_pump.md
SWC_PACKET_MEM_WRITE_PUMP -- requirements
Module: swc_packet_mem_write_pump

Interface
REQ-001 Parameter PAGE_ADDR_BITS, default 10: width of page address.
REQ-002 Parameter DATA_WIDTH, default 32: width of one input word.
REQ-003 Parameter MULTIPLY, default 16: words per memory line.
REQ-004 Port clk_i  in  1: single clock; all logic on rising edge.
REQ-005 Port rst_i  in  1: reset, asynchronous, active-high.
REQ-006 Port pgaddr_i  in  PAGE_ADDR_BITS: page address of the line being filled.
REQ-007 Port pgreq_i  in  1: load pgaddr_i into the page register.
REQ-008 Port d_i  in  DATA_WIDTH: input word.
REQ-009 Port drdy_i  in  1: d_i valid this cycle.
REQ-010 Port flush_i  in  1: commit a partially filled line.
REQ-011 Port full_o  out  1: line pending; upstream must not assert drdy_i.
REQ-012 Port sync_i  in  1: memory write slot, one-hot rotating, high 1 cycle in MULTIPLY.
REQ-013 Port we_o  out  1: memory write strobe.
REQ-014 Port addr_o  out  PAGE_ADDR_BITS: memory line address.
REQ-015 Port q_o  out  DATA_WIDTH*MULTIPLY: memory line data.
REQ-016 Port pgend_o  out  1: one-cycle pulse, line committed to memory.

Function
REQ-017 States: FILL, WAIT_SYNC; reset state FILL.
REQ-018 FILL: drdy_i=1 stores d_i into slot cnt; cnt increments; cnt range 0..MULTIPLY-1.
REQ-019 Word k maps to q_o[DATA_WIDTH*(MULTIPLY-k)-1 -: DATA_WIDTH], so word 0 is in the MSBs.
REQ-020 Word accepted with cnt=MULTIPLY-1: cnt wraps to 0, next state WAIT_SYNC.
REQ-021 flush_i in FILL with cnt>0: next state WAIT_SYNC; unwritten slots read as zero at commit.
REQ-022 flush_i in FILL with cnt=0 and drdy_i=0: ignored, no write.
REQ-023 flush_i and drdy_i in the same cycle: word stored first, then flush applies (one-word line if cnt was 0).
REQ-024 Page register loads on every pgreq_i, in any state.
REQ-025 Line address is captured from the page register on the FILL->WAIT_SYNC transition and drives addr_o.
REQ-026 full_o is registered: 1 exactly while in WAIT_SYNC.
REQ-027 drdy_i while full_o=1 is ignored; no data loss is guaranteed only if upstream honours full_o.
REQ-028 WAIT_SYNC with sync_i=1: we_o=1 combinationally in that cycle; q_o and addr_o are stable.
REQ-029 WAIT_SYNC with sync_i=1: pgend_o pulses next cycle, state returns to FILL, line buffer clears, cnt=0.
REQ-030 sync_i in FILL has no effect; we_o=0 outside WAIT_SYNC.
REQ-031 Worst-case commit latency is MULTIPLY cycles from entry to WAIT_SYNC; the first accept after commit is possible the cycle after we_o.

Reset
REQ-032 rst_i asynchronously forces: state FILL, cnt 0, line buffer 0, page and line address 0, full_o 0, we_o 0, pgend_o 0.
REQ-033 rst_i mid-line or in WAIT_SYNC discards pending data with no write issued.
REQ-034 Normal operation resumes on the first rising edge after rst_i deasserts.

Structure
REQ-035 Shared package swc_pump_pkg holds PAGE_ADDR_BITS, DATA_WIDTH, MULTIPLY defaults and the state encoding, shared with the read pump.
REQ-036 Single module with no sub-module; counter, line register and FSM live inline.

Verification
REQ-037 Feed 16 consecutive words 0x0..0xF, page 0x2A -> full_o=1, then we_o=1 on the next sync_i with q_o = 0x00000000_00000001_..._0000000F and addr_o=0x2A.
REQ-038 Feed 3 words, then flush_i -> single write whose top 3 words are the inputs and the remaining 13 are zero; pgend_o pulses once.
REQ-039 Drive drdy_i while full_o=1 with value 0xDEAD -> value absent from the committed line; the next line starts at cnt 0.
REQ-040 Assert pgreq_i with 0x3FF during WAIT_SYNC of a line started on page 0x001 -> commit uses addr 0x001; the next line uses 0x3FF.
REQ-041 Assert rst_i during WAIT_SYNC before sync_i -> no we_o; all outputs at reset values immediately.
REQ-042 Run 17 lines back-to-back with gaps 0..16 cycles and sync_i rotating -> exactly 17 writes, data in order, none lost.
